// File: rtl/mux_seq_nx1.sv
// N-channel, DATA_W-bit sequencing multiplexer with a registered valid/ready
// output. Manual mode streams a software-selected channel; scan mode walks
// the enabled channels in ascending order with a programmable dwell and tags
// each sample with its channel index.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | parked; picks manual or scan from mode (scan needs |ch_mask)
// MANUAL | capture data_in[cur_sel] on every edge with a free slot
// DWELL  | scan settle time, dwell+1 cycles on the current channel
// EMIT   | scan capture of the current channel, then advance the pointer
module mux_seq_nx1 #(
    parameter int N_CH    = 16,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     sel_load,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         out_ch,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     scan_wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        DWELL  = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [SEL_W-1:0]     cur_sel_nx;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_cnt_nx;
    logic [SEL_W-1:0]     first_ge;
    logic [SEL_W-1:0]     next_gt;
    logic                 capture;
    logic                 wrap_nx;
    logic                 any_en;
    logic                 slot_free;
    logic                 sel_ok;
    logic [DATA_W-1:0]    sel_data;

    assign any_en    = |ch_mask;
    assign slot_free = !out_valid || out_ready;
    // Non-power-of-two channel counts leave select codes with no channel.
    assign sel_ok    = (int'(sel_in) < N_CH);
    assign sel_data  = data_in[int'(cur_sel)*DATA_W +: DATA_W];

    // Circular priority search from the current pointer: first enabled
    // channel at or above it (scan entry) and first strictly above it
    // (scan advance). The last offset of the advance search lands back on
    // cur_sel itself, so a lone enabled channel re-selects itself.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_sel;
        logic             found_ge;
        logic             found_gt;
        idx      = 0;
        idx_sel  = '0;
        found_ge = 1'b0;
        found_gt = 1'b0;
        first_ge = cur_sel;
        next_gt  = cur_sel;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(cur_sel) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            idx_sel = SEL_W'(idx);
            if (!found_ge && ch_mask[idx_sel]) begin
                found_ge = 1'b1;
                first_ge = idx_sel;
            end
            idx = int'(cur_sel) + k + 1;
            if (idx >= N_CH) idx = idx - N_CH;
            idx_sel = SEL_W'(idx);
            if (!found_gt && ch_mask[idx_sel]) begin
                found_gt = 1'b1;
                next_gt  = idx_sel;
            end
        end
    end

    // Next-state, pointer, dwell counter and capture decisions.
    always_comb begin
        state_nx     = state;
        cur_sel_nx   = cur_sel;
        dwell_cnt_nx = dwell_cnt;
        capture      = 1'b0;
        wrap_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (!mode) begin
                    state_nx = MANUAL;
                    if (sel_load && sel_ok) cur_sel_nx = sel_in;
                end else if (any_en) begin
                    state_nx     = DWELL;
                    cur_sel_nx   = first_ge;
                    dwell_cnt_nx = '0;
                end
            end
            MANUAL: begin
                if (mode) begin
                    state_nx = IDLE;
                end else begin
                    // Capture uses the pointer before any load on this edge.
                    capture = slot_free;
                    if (sel_load && sel_ok) cur_sel_nx = sel_in;
                end
            end
            DWELL: begin
                if (!mode || !any_en) begin
                    state_nx = IDLE;
                end else if (dwell_cnt == dwell) begin
                    state_nx = EMIT;
                end else begin
                    dwell_cnt_nx = dwell_cnt + 1'b1;
                end
            end
            EMIT: begin
                if (!mode || !any_en) begin
                    state_nx = IDLE;
                end else if (slot_free) begin
                    // A channel disabled during its dwell is skipped silently.
                    capture      = ch_mask[cur_sel];
                    cur_sel_nx   = next_gt;
                    wrap_nx      = (next_gt <= cur_sel);
                    state_nx     = DWELL;
                    dwell_cnt_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pointer, dwell counter, wrap pulse and output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel   <= '0;
            dwell_cnt <= '0;
            scan_wrap <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_ch    <= '0;
        end else begin
            cur_sel   <= cur_sel_nx;
            dwell_cnt <= dwell_cnt_nx;
            scan_wrap <= wrap_nx;
            if (capture) begin
                out_valid <= 1'b1;
                data_out  <= sel_data;
                out_ch    <= cur_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_seq_nx1.sv
// Directed bench for mux_seq_nx1: stimulus pushes expected samples into a
// queue, an independent monitor pops one per output transfer.
module tb_mux_seq_nx1;

    localparam int N_CH    = 16;
    localparam int DATA_W  = 8;
    localparam int SEL_W   = 4;
    localparam int DWELL_W = 8;

    logic                   clk;
    logic                   rst_n;
    logic [N_CH*DATA_W-1:0] data_in;
    logic                   mode;
    logic [SEL_W-1:0]       sel_in;
    logic                   sel_load;
    logic [N_CH-1:0]        ch_mask;
    logic [DWELL_W-1:0]     dwell;
    logic                   out_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      data_out;
    logic [SEL_W-1:0]       out_ch;
    logic [SEL_W-1:0]       cur_sel;
    logic                   scan_wrap;

    typedef struct {
        logic [SEL_W-1:0]  ch;
        logic [DATA_W-1:0] data;
        logic              wrap;
        int                gap;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_item;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   last_xfer = 0;
    int   wrap_cnt  = 0;
    bit   mon_en    = 1'b0;

    mux_seq_nx1 #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .mode      (mode),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .out_ch    (out_ch),
        .cur_sel   (cur_sel),
        .scan_wrap (scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_n && scan_wrap) wrap_cnt = wrap_cnt + 1;

    // Monitor: inputs only change just after a rising edge, so valid&ready
    // seen here means a transfer on the coming edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (mon_en) begin
                checks = checks + 1;
                if (sb_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_sample actual ch=%0d data=%02h expected none",
                             out_ch, data_out);
                end else begin
                    mon_item = sb_q.pop_front();
                    if (out_ch !== mon_item.ch || data_out !== mon_item.data ||
                        scan_wrap !== mon_item.wrap) begin
                        errors = errors + 1;
                        $display("FAIL sample actual ch=%0d data=%02h wrap=%0b expected ch=%0d data=%02h wrap=%0b",
                                 out_ch, data_out, scan_wrap, mon_item.ch, mon_item.data, mon_item.wrap);
                    end
                    if (mon_item.gap != 0) begin
                        checks = checks + 1;
                        if (cyc - last_xfer != mon_item.gap) begin
                            errors = errors + 1;
                            $display("FAIL sample_gap actual=%0d expected=%0d",
                                     cyc - last_xfer, mon_item.gap);
                        end
                    end
                end
            end
            last_xfer = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int data, input bit wrap, input int gap);
        exp_t e;
        e.ch   = SEL_W'(ch);
        e.data = DATA_W'(data);
        e.wrap = wrap;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain_timeout actual=%0d pending expected=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        mode      = 1'b0;
        sel_in    = '0;
        sel_load  = 1'b0;
        ch_mask   = '0;
        dwell     = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) data_in[i*DATA_W +: DATA_W] = DATA_W'(8'hA0 + i);
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_out_ch",    32'(out_ch),    32'd0);
        check("rst_cur_sel",   32'(cur_sel),   32'd0);
        check("rst_scan_wrap", 32'(scan_wrap), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Manual stream: the load edge still captures the old channel 0.
        mon_en = 1'b1;
        push(0, 8'hA0, 1'b0, 0);
        for (int i = 0; i < 5; i++) push(3, 8'hA3, 1'b0, 1);
        sel_in    = 4'd3;
        sel_load  = 1'b1;
        out_ready = 1'b1;
        tick();
        sel_load = 1'b0;
        drain(20);
        mon_en = 1'b0;

        // Backpressure on channel 5 while its input changes.
        sel_in   = 4'd5;
        sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        tick();
        out_ready = 1'b0;
        data_in[5*DATA_W +: DATA_W] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data",  32'(data_out),  32'hA5);
        end
        check("hold_ch", 32'(out_ch), 32'd5);
        mon_en = 1'b1;
        push(5, 8'hA5, 1'b0, 0);
        push(5, 8'h11, 1'b0, 1);
        out_ready = 1'b1;
        drain(20);
        mon_en = 1'b0;
        data_in[5*DATA_W +: DATA_W] = 8'hA5;

        // Scan order over mask 0x8025 from pointer 0, dwell 2.
        sel_in   = 4'd0;
        sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        mode     = 1'b1;
        ch_mask  = 16'h8025;
        dwell    = 8'd2;
        tick();
        mon_en   = 1'b1;
        wrap_cnt = 0;
        push(0,  8'hA0, 1'b0, 0);
        push(2,  8'hA2, 1'b0, 4);
        push(5,  8'hA5, 1'b0, 4);
        push(15, 8'hAF, 1'b1, 4);
        push(0,  8'hA0, 1'b0, 4);
        drain(60);
        check("scan_wrap_count", 32'(wrap_cnt), 32'd1);

        // Empty mask: no samples, pointer held.
        ch_mask = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("empty_mask_valid", 32'(out_valid), 32'd0);
        end
        check("empty_mask_cur_sel", 32'(cur_sel), 32'd2);

        // Single channel 8: wrap on every advance.
        wrap_cnt = 0;
        ch_mask  = 16'h0100;
        push(8, 8'hA8, 1'b1, 0);
        push(8, 8'hA8, 1'b1, 4);
        push(8, 8'hA8, 1'b1, 4);
        drain(60);
        check("single_wrap_count", 32'(wrap_cnt), 32'd3);

        // Channel 8 disabled mid-dwell: skipped, scan resumes at 15.
        ch_mask = 16'h8025;
        push(15, 8'hAF, 1'b1, 0);
        push(0,  8'hA0, 1'b0, 4);
        drain(60);

        // Mode switch mid-dwell on channel 5: manual stream, no scan sample.
        push(2, 8'hA2, 1'b0, 0);
        drain(30);
        mode  = 1'b0;
        dwell = 8'd6;
        push(5, 8'hA5, 1'b0, 4);
        push(5, 8'hA5, 1'b0, 1);
        push(5, 8'hA5, 1'b0, 1);
        drain(30);
        mon_en = 1'b0;

        // Async reset while EMIT is stalled with a pending sample.
        out_ready = 1'b0;
        mode      = 1'b1;
        dwell     = 8'd0;
        repeat (4) tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data",  32'(data_out),  32'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_data_out",  32'(data_out),  32'd0);
        check("async_out_ch",    32'(out_ch),    32'd0);
        check("async_cur_sel",   32'(cur_sel),   32'd0);
        check("async_scan_wrap", 32'(scan_wrap), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
